// File: rtl/vga_pkg.sv
// Shared timing constants, sync-polarity encoding and width helpers for the
// VGA timing generator and its pixel-side consumers.
package vga_pkg;

   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   typedef enum logic {
      SYNC_ACT_LOW  = 1'b0,
      SYNC_ACT_HIGH = 1'b1
   } sync_pol_e;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Pin level for an internal active-high sync flag under the given polarity.
   function automatic logic sync_level(input logic act, input sync_pol_e pol);
      return act ~^ logic'(pol);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request / colour return bus between the timing generator (master)
// and the per-pixel drawing logic (slave).
interface vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10,
   parameter int CW = 6
);
   logic [XW-1:0] x_out;
   logic [YW-1:0] y_out;
   logic          active_out;
   logic          line_start;
   logic          frame_start;
   logic [7:0]    frame_cnt;
   logic [CW-1:0] rgb_in;

   modport master (
      output x_out, y_out, active_out, line_start, frame_start, frame_cnt,
      input  rgb_in
   );

   modport slave (
      input  x_out, y_out, active_out, line_start, frame_start, frame_cnt,
      output rgb_in
   );
endinterface

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with synchronous clear; DEPTH=0 is a wire.
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = ^{clk, rst, ce};
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] sr [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (ce) begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, early pixel request
// stage, and sync/DE/colour re-alignment through a configurable delay.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VIS      = DEF_H_VIS,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_VIS      = DEF_V_VIS,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int COLOR_BITS = 2,
   parameter int PIPE_DELAY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pix_ce,
   vga_timing_gen_if.master        pix,
   output logic                    vga_hs,
   output logic                    vga_vs,
   output logic                    vga_de,
   output logic [3*COLOR_BITS-1:0] vga_rgb
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int XW      = cnt_width(H_TOTAL);
   localparam int YW      = cnt_width(V_TOTAL);
   localparam int HS_BEG  = H_VIS + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_VIS + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;

   localparam sync_pol_e HS_P = sync_pol_e'(HS_POL);
   localparam sync_pol_e VS_P = sync_pol_e'(VS_POL);

   generate
      if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
          V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
         $error("vga_timing_gen: porch and sync widths must be non-zero");
      end
      if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
         $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
      end
   endgenerate

   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic          h_last;
   logic          v_last;

   assign h_last = (h == XW'(H_TOTAL - 1));
   assign v_last = (v == YW'(V_TOTAL - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         h             <= '0;
         v             <= '0;
         pix.frame_cnt <= '0;
      end else if (pix_ce) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
         if (h_last && v_last) pix.frame_cnt <= pix.frame_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix.x_out       <= '0;
         pix.y_out       <= '0;
         pix.active_out  <= 1'b0;
         pix.line_start  <= 1'b0;
         pix.frame_start <= 1'b0;
      end else if (pix_ce) begin
         pix.x_out       <= h;
         pix.y_out       <= v;
         pix.active_out  <= (h < XW'(H_VIS)) && (v < YW'(V_VIS));
         pix.line_start  <= (h == '0);
         pix.frame_start <= (h == '0) && (v == '0);
      end
   end

   // Syncs are decoded from the request stage so they share its tick of latency
   // and line up with the colour returned for the same coordinate.
   logic hs_req;
   logic vs_req;

   always_comb begin
      hs_req = (pix.x_out >= XW'(HS_BEG)) && (pix.x_out < XW'(HS_END));
      vs_req = (pix.y_out >= YW'(VS_BEG)) && (pix.y_out < YW'(VS_END));
   end

   logic hs_d;
   logic vs_d;
   logic de_d;

   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_DELAY)
   ) u_align (
      .clk (clk),
      .rst (rst),
      .ce  (pix_ce),
      .d   ({hs_req, vs_req, pix.active_out}),
      .q   ({hs_d, vs_d, de_d})
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_hs  <= sync_level(1'b0, HS_P);
         vga_vs  <= sync_level(1'b0, VS_P);
         vga_de  <= 1'b0;
         vga_rgb <= '0;
      end else if (pix_ce) begin
         vga_hs  <= sync_level(hs_d, HS_P);
         vga_vs  <= sync_level(vs_d, VS_P);
         vga_de  <= de_d;
         vga_rgb <= de_d ? pix.rgb_in : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default mode (A), default mode at half pixel rate (C) and
// a tiny active-high-hsync mode without pipeline delay (B).
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b1;
   logic rst_s = 1'b1;
   logic ce_a  = 1'b0;
   logic ce_s  = 1'b0;
   logic ce_c  = 1'b1;
   int   cyc   = 0;

   always @(posedge clk) if (!rst) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      ce_c = (cyc % 2 == 0);
   end

   vga_timing_gen_if #(.XW(10), .YW(10), .CW(6)) pix_a ();
   vga_timing_gen_if #(.XW(10), .YW(10), .CW(6)) pix_c ();
   vga_timing_gen_if #(.XW(4),  .YW(4),  .CW(6)) pix_b ();

   logic       hs_a, vs_a, de_a, hs_c, vs_c, de_c, hs_b, vs_b, de_b;
   logic [5:0] rgb_a, rgb_c, rgb_b;
   logic [5:0] rgb_gen = '0;

   // One-tick pixel generator: colour = x[5:0], saturated white in blanking.
   always @(posedge clk) if (ce_a) rgb_gen <= (pix_a.x_out >= 10'd640) ? 6'h3F : pix_a.x_out[5:0];
   assign pix_a.rgb_in = rgb_gen;
   assign pix_c.rgb_in = 6'h3F;
   assign pix_b.rgb_in = 6'h2A;

   vga_timing_gen u_a (
      .clk(clk), .rst(rst), .pix_ce(ce_a), .pix(pix_a),
      .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a)
   );

   vga_timing_gen u_c (
      .clk(clk), .rst(rst), .pix_ce(ce_c), .pix(pix_c),
      .vga_hs(hs_c), .vga_vs(vs_c), .vga_de(de_c), .vga_rgb(rgb_c)
   );

   vga_timing_gen #(
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_BITS(2), .PIPE_DELAY(0)
   ) u_b (
      .clk(clk), .rst(rst_s), .pix_ce(ce_s), .pix(pix_b),
      .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b)
   );

   typedef enum int {
      A_HS, A_VS, A_DE, A_RGB, A_X, A_Y, A_ACT, A_LS, A_FS, A_FC,
      B_HS, B_VS, B_DE, B_RGB, B_X, B_Y, B_ACT, B_LS, B_FS, B_FC, B_DECNT,
      C_HS, C_VS, C_DE, A_LEAK, C_VIOL
   } sig_e;

   typedef struct { sig_e id; int exp; } snap_t;
   typedef struct { int px;   int val; } pix_t;

   snap_t q_snap[$];
   pix_t  q_pix[$];
   int    q_at[5][$];
   int    q_w[5][$];
   logic  tprev[5] = '{default: 1'b0};
   int    t0[5]    = '{default: 0};
   string tname[5] = '{"a_hs", "c_hs", "b_hs", "b_vs", "a_de"};

   int n_chk  = 0;
   int n_err  = 0;
   int leak_a = 0;
   int viol_c = 0;
   int decnt_b = 0;
   logic [39:0] c_vec, c_prev;

   task automatic chk(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic snap(input sig_e id, input int e);
      q_snap.push_back('{id, e});
   endtask

   function automatic int act(input sig_e id);
      case (id)
         A_HS:    return int'(hs_a);
         A_VS:    return int'(vs_a);
         A_DE:    return int'(de_a);
         A_RGB:   return int'(rgb_a);
         A_X:     return int'(pix_a.x_out);
         A_Y:     return int'(pix_a.y_out);
         A_ACT:   return int'(pix_a.active_out);
         A_LS:    return int'(pix_a.line_start);
         A_FS:    return int'(pix_a.frame_start);
         A_FC:    return int'(pix_a.frame_cnt);
         B_HS:    return int'(hs_b);
         B_VS:    return int'(vs_b);
         B_DE:    return int'(de_b);
         B_RGB:   return int'(rgb_b);
         B_X:     return int'(pix_b.x_out);
         B_Y:     return int'(pix_b.y_out);
         B_ACT:   return int'(pix_b.active_out);
         B_LS:    return int'(pix_b.line_start);
         B_FS:    return int'(pix_b.frame_start);
         B_FC:    return int'(pix_b.frame_cnt);
         B_DECNT: return decnt_b;
         C_HS:    return int'(hs_c);
         C_VS:    return int'(vs_c);
         C_DE:    return int'(de_c);
         A_LEAK:  return leak_a;
         C_VIOL:  return viol_c;
         default: return -1;
      endcase
   endfunction

   // Assertion onset is checked against an expected cycle, release against a width.
   task automatic track(input int id, input logic a);
      if (a && !tprev[id]) begin
         t0[id] = cyc;
         if (q_at[id].size() > 0) chk({tname[id], "_assert_cyc"}, cyc, q_at[id].pop_front());
      end
      if (!a && tprev[id]) begin
         if (q_w[id].size() > 0) chk({tname[id], "_width"}, cyc - t0[id], q_w[id].pop_front());
      end
      tprev[id] = a;
   endtask

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         if (de_a === 1'b0 && rgb_a !== 6'd0) leak_a++;
         if (de_b === 1'b1 && cyc <= 150) decnt_b++;
         c_vec = {hs_c, vs_c, de_c, rgb_c, pix_c.x_out, pix_c.y_out, pix_c.active_out,
                  pix_c.line_start, pix_c.frame_start, pix_c.frame_cnt};
         if (cyc % 2 == 0 && c_vec !== c_prev) viol_c++;
         c_prev = c_vec;
         track(0, hs_a === 1'b0);
         track(1, hs_c === 1'b0);
         track(2, hs_b === 1'b1);
         track(3, vs_b === 1'b0);
         track(4, de_a === 1'b1);
         if (de_a === 1'b1 && q_pix.size() > 0 && (cyc - t0[4]) == q_pix[0].px) begin
            pix_t pe;
            pe = q_pix.pop_front();
            chk($sformatf("a_rgb_px%0d", pe.px), int'(rgb_a), pe.val);
         end
      end
      while (q_snap.size() > 0) begin
         snap_t s;
         s = q_snap.pop_front();
         chk(s.id.name(), act(s.id), s.exp);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   task automatic to_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap_reset_b();
      snap(B_HS, 0); snap(B_VS, 1); snap(B_DE, 0); snap(B_RGB, 0); snap(B_FC, 0);
      snap(B_X, 0);  snap(B_Y, 0);  snap(B_ACT, 0); snap(B_LS, 0); snap(B_FS, 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         q_at[0].push_back(659 + 800 * k); q_w[0].push_back(96);
         q_w[4].push_back(640);
         q_at[2].push_back(12 + 15 * k);   q_w[2].push_back(3);
      end
      for (int k = 0; k < 2; k++) begin
         q_at[1].push_back(1317 + 1600 * k); q_w[1].push_back(192);
         q_at[3].push_back(107 + 150 * k);   q_w[3].push_back(30);
      end
      q_pix.push_back('{5, 5});
      q_pix.push_back('{63, 63});
      q_pix.push_back('{64, 0});
      q_pix.push_back('{639, 63});

      repeat (2) @(posedge clk);
      #1;
      snap(A_HS, 1); snap(A_VS, 1); snap(A_DE, 0); snap(A_RGB, 0); snap(A_FC, 0);
      snap(A_X, 0);  snap(A_Y, 0);  snap(A_ACT, 0); snap(A_LS, 0); snap(A_FS, 0);
      snap(C_HS, 1); snap(C_VS, 1); snap(C_DE, 0);
      snap_reset_b();
      rst = 1'b0; rst_s = 1'b0; ce_a = 1'b1; ce_s = 1'b1;

      to_cyc(1);
      snap(A_X, 0); snap(A_Y, 0); snap(A_FS, 1); snap(A_LS, 1); snap(A_ACT, 1); snap(A_DE, 0);
      snap(B_X, 0); snap(B_Y, 0); snap(B_FS, 1); snap(B_LS, 1); snap(B_DE, 0); snap(B_RGB, 0);
      to_cyc(2);
      snap(A_X, 1); snap(A_FS, 0); snap(A_LS, 0); snap(A_DE, 0);
      snap(B_DE, 1); snap(B_RGB, 42); snap(B_HS, 0);
      to_cyc(3);
      snap(A_DE, 1);
      to_cyc(83);
      snap(B_X, 7); snap(B_Y, 5); snap(B_ACT, 1);
      to_cyc(84);
      snap(B_X, 8); snap(B_ACT, 0);
      to_cyc(149);
      snap(B_FC, 0);
      to_cyc(150);
      snap(B_FC, 1); snap(B_X, 14); snap(B_Y, 9); snap(B_FS, 0);
      to_cyc(151);
      snap(B_FS, 1); snap(B_LS, 1); snap(B_X, 0); snap(B_Y, 0); snap(B_FC, 1); snap(B_DECNT, 48);
      to_cyc(640);
      snap(A_X, 639); snap(A_ACT, 1);
      to_cyc(641);
      snap(A_X, 640); snap(A_ACT, 0);
      to_cyc(38250);
      snap(B_FC, 255);
      to_cyc(38399);
      snap(B_FC, 255);
      to_cyc(38400);
      snap(B_FC, 0);
      to_cyc(38550);
      snap(B_FC, 1);

      to_cyc(38684);
      snap(B_HS, 1); snap(B_VS, 0); snap(B_FC, 1);
      rst_s = 1'b1; ce_s = 1'b0;
      to_cyc(38685);
      snap_reset_b();
      rst_s = 1'b0; ce_s = 1'b1;
      to_cyc(38686);
      snap(B_X, 0); snap(B_Y, 0); snap(B_FS, 1); snap(B_LS, 1); snap(B_ACT, 1);
      snap(B_DE, 0); snap(B_FC, 0); snap(B_HS, 0); snap(B_VS, 1);
      to_cyc(38687);
      snap(B_DE, 1); snap(B_RGB, 42);
      to_cyc(38690);
      q_at[2].push_back(38697); q_w[2].push_back(3);
      q_at[3].push_back(38792); q_w[3].push_back(30);

      to_cyc(38830);
      snap(A_LEAK, 0); snap(C_VIOL, 0);
      @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk({"pending_", tname[i], "_assert"}, q_at[i].size(), 0);
         chk({"pending_", tname[i], "_width"},  q_w[i].size(),  0);
      end
      chk("pending_a_pixels", q_pix.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator: next generation of the fixed 640x480 sync logic inside the clock display.
- Generates hsync/vsync/data-enable for any mode, publishes pixel coordinates early so a pixel generator can run ahead, and re-aligns the returned colour with the syncs through a configurable pipeline delay.
- Supports a pixel clock-enable, so one fast system clock can drive a slower pixel rate.
- Sits between the top-level pin mapping and the per-pixel drawing logic.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active low)
- VS_POL, 0, active level of vsync
- COLOR_BITS, 2, bits per colour channel
- PIPE_DELAY, 1, pixel-generator latency in pixel ticks (legal 0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- pix_ce  in  1  pixel tick; all state advances only when high
- x_out  out  XW  column of pixel being requested; XW = clog2(H_VIS+H_FP+H_SYNC+H_BP)
- y_out  out  YW  line of pixel being requested; YW = clog2(V total)
- active_out  out  1  requested pixel is visible
- line_start  out  1  one-tick pulse, requested pixel is x=0
- frame_start  out  1  one-tick pulse, requested pixel is (0,0)
- frame_cnt  out  8  completed-frame counter
- rgb_in  in  3*COLOR_BITS  {r,g,b} from pixel generator
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  data enable
- vga_rgb  out  3*COLOR_BITS  {r,g,b}, forced to 0 while blanked

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
- Counters h and v update only on clk edges where pix_ce=1.
  - h runs 0..H_TOTAL-1, then wraps to 0.
  - v increments when h wraps; v wraps to 0 after V_TOTAL-1.
- When pix_ce=0, every register holds, including the pipeline and outputs.
- Request stage, latency 1 tick: x_out/y_out = previous h/v.
  - active_out = (h<H_VIS)&&(v<V_VIS).
  - line_start = (h==0).
  - frame_start = (h==0)&&(v==0).
- Sync decode (before delay):
  - hs_raw = H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC.
  - vs_raw = V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC.
  - Outputs are XOR'd so the inactive level is ~POL.
- hs, vs and active pass through a PIPE_DELAY-deep shift register (a wire when PIPE_DELAY=0), then through one output register.
  - Net latency from counter to vga_* is PIPE_DELAY+2 ticks.
- rgb_in must be valid PIPE_DELAY ticks after the matching x_out/y_out.
  - It is captured in the output register with the delayed active.
  - vga_rgb = de ? rgb_in : 0.
- frame_cnt increments (mod 256, 255->0) on the tick where h=H_TOTAL-1 and v=V_TOTAL-1.
- Reset values (next edge after rst=1, regardless of pix_ce):
  - h=v=0, frame_cnt=0.
  - Pipeline flushed to inactive syncs, de=0.
  - x_out=y_out=0, active_out=0, line_start=frame_start=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, vga_rgb=0.
- Reset asserted mid-line or mid-frame: identical result, no partial sync pulse survives.
  - After release, the first tick reproduces a clean frame start.
- Simultaneous h and v wrap on one tick: v→0, frame_cnt increments, and the next request stage raises both frame_start and line_start.
- Elaboration must fail (generate-time $error) if any porch/sync parameter is 0 or PIPE_DELAY>7.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants;
  - a sync-polarity encoding;
  - a clog2-based width helper function.
- One natural sub-module: vga_delay_line (parametrised width/depth, pix_ce-gated shift register, synchronous clear). It is used for the hs/vs/de alignment and is reusable.

Test Plan:
- Default params, pix_ce=1, rst pulse → vga_hs low exactly 96 clks per 800; first hs low edge at clk 656+3 after reset release (PIPE_DELAY=1).
- Full frame → vga_vs low for 2 lines (1600 clks) per 420000-clk frame; vga_de high count = 640*480 = 307200; frame_cnt=1 after the frame.
- pix_ce toggling 1,0,1,0 → every output period doubles (hsync low 192 clks); outputs hold constant on pix_ce=0 cycles.
- rgb_in = x_out[5:0] fed through a 1-tick model, PIPE_DELAY=1 → vga_rgb on pixel 5 = 6'd5, and 0 during blanking even when rgb_in=6'h3F.
- Assert rst at h=700, v=490 (mid-vsync) → next edge vga_vs=1, vga_hs=1, de=0, frame_cnt=0; after release x_out=0, y_out=0, frame_start=1 on the first tick.
- HS_POL=1, PIPE_DELAY=0, H_VIS=8 small mode → hs idles 0, pulses high; sync latency is 2 ticks; frame_cnt wraps 255→0 after 256 frames.
